dl_fetch: RTL and testbench

//  Display-list walker and graphics fetcher for Maria; drives the write side of the line RAM.
//  Per zone line it reads DL headers (4- and 5-byte), fetches each object's graphics bytes

---
 rtl/dl_fetch_if.sv | 35 +++
 rtl/dl_fetch.sv | 237 +++++++++++++++++++++++
 tb/tb_dl_fetch.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dl_fetch_if.sv
// Signal bundle between the display-list fetcher, the DMA memory port and the line RAM write side.
// The fetcher uses the master view; whatever drives its control inputs and memory responses uses the slave view.
interface dl_fetch_if;
  logic        DL_START;
  logic        DL_ABORT;
  logic [15:0] DL_ADDR;
  logic [3:0]  OFFSET;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [7:0]  MEM_DATA;
  logic [7:0]  INPUT_ADDR;
  logic        INPUT_W;
  logic [2:0]  PALETTE;
  logic        PALETTE_W;
  logic        WM;
  logic        WM_W;
  logic [7:0]  PIXELS;
  logic        PIXELS_W;
  logic        BUSY;
  logic        DONE;
  logic        OVERRUN;

  modport master (
    input  DL_START, DL_ABORT, DL_ADDR, OFFSET, MEM_ACK, MEM_DATA,
    output MEM_REQ, MEM_ADDR, INPUT_ADDR, INPUT_W, PALETTE, PALETTE_W,
           WM, WM_W, PIXELS, PIXELS_W, BUSY, DONE, OVERRUN
  );

  modport slave (
    output DL_START, DL_ABORT, DL_ADDR, OFFSET, MEM_ACK, MEM_DATA,
    input  MEM_REQ, MEM_ADDR, INPUT_ADDR, INPUT_W, PALETTE, PALETTE_W,
           WM, WM_W, PIXELS, PIXELS_W, BUSY, DONE, OVERRUN
  );
endinterface

// File: rtl/dl_fetch.sv
// Maria display-list walker: parses 4/5-byte headers, fetches direct-object graphics bytes
// over a req/ack port and emits palette/hpos/write-mode/pixel strobes to the line RAM.
module dl_fetch #(
  parameter int MAX_ENTRIES = 32
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  dl_fetch_if.master bus
);
  localparam int CW = $clog2(MAX_ENTRIES + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_ENTRIES);

  typedef enum logic [3:0] {IDLE, H0, H1, H2, H3, H4, EMIT, GFX, FIN} state_t;

  state_t        state_r;
  logic [15:0]   dl_ptr_r;
  logic [CW-1:0] count_r;
  logic [7:0]    lo_r;
  logic [7:0]    hi_r;
  logic [2:0]    pal_r;
  logic [4:0]    wfield_r;
  logic          ext_r;
  logic          wm_r;
  logic          ind_r;
  logic [5:0]    n_r;
  logic [5:0]    idx_r;
  logic          req_r;
  logic [15:0]   addr_r;
  logic [7:0]    input_addr_r;
  logic          input_w_r;
  logic [2:0]    palette_r;
  logic          palette_w_r;
  logic          wm_out_r;
  logic          wm_w_r;
  logic [7:0]    pixels_r;
  logic          pixels_w_r;
  logic          busy_r;
  logic          done_r;
  logic          overrun_r;

  logic          ack_s;
  logic          fetch_s;
  logic [7:0]    hi_off_s;
  logic [15:0]   gfx_addr_s;
  logic [CW-1:0] count_inc_s;
  logic [7:0]    data_s;

  assign data_s      = bus.MEM_DATA;
  assign ack_s       = req_r & bus.MEM_ACK;
  assign fetch_s     = (state_r == H0) || (state_r == H1) || (state_r == H2) ||
                       (state_r == H3) || (state_r == H4) || (state_r == GFX);
  // High byte and the 16-bit object address wrap independently.
  assign hi_off_s    = hi_r + {4'd0, bus.OFFSET};
  assign gfx_addr_s  = {hi_off_s, lo_r} + {10'd0, idx_r};
  assign count_inc_s = count_r + {{(CW-1){1'b0}}, 1'b1};

  // Walker state machine, memory handshake and registered line-RAM strobes.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      dl_ptr_r     <= 16'd0;
      count_r      <= {CW{1'b0}};
      lo_r         <= 8'd0;
      hi_r         <= 8'd0;
      pal_r        <= 3'd0;
      wfield_r     <= 5'd0;
      ext_r        <= 1'b0;
      wm_r         <= 1'b0;
      ind_r        <= 1'b0;
      n_r          <= 6'd0;
      idx_r        <= 6'd0;
      req_r        <= 1'b0;
      addr_r       <= 16'd0;
      input_addr_r <= 8'd0;
      input_w_r    <= 1'b0;
      palette_r    <= 3'd0;
      palette_w_r  <= 1'b0;
      wm_out_r     <= 1'b0;
      wm_w_r       <= 1'b0;
      pixels_r     <= 8'd0;
      pixels_w_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (bus.DL_ABORT) begin
      // A coincident ACK is dropped; a PIXELS_W registered last edge has already fired.
      state_r     <= IDLE;
      req_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      input_w_r   <= 1'b0;
      palette_w_r <= 1'b0;
      wm_w_r      <= 1'b0;
      pixels_w_r  <= 1'b0;
    end else begin
      input_w_r   <= 1'b0;
      palette_w_r <= 1'b0;
      wm_w_r      <= 1'b0;
      pixels_w_r  <= 1'b0;
      done_r      <= 1'b0;

      if (fetch_s && !req_r) begin
        req_r  <= 1'b1;
        addr_r <= (state_r == GFX) ? gfx_addr_s : dl_ptr_r;
      end else if (ack_s) begin
        req_r <= 1'b0;
        if (state_r != GFX) begin
          dl_ptr_r <= dl_ptr_r + 16'd1;
        end else begin
          dl_ptr_r <= dl_ptr_r;
        end
      end else begin
        req_r <= req_r;
      end

      case (state_r)
        IDLE: begin
          if (bus.DL_START) begin
            state_r   <= H0;
            dl_ptr_r  <= bus.DL_ADDR;
            busy_r    <= 1'b1;
            overrun_r <= 1'b0;
            count_r   <= {CW{1'b0}};
          end
        end
        H0: begin
          if (ack_s) begin
            lo_r    <= data_s;
            state_r <= H1;
          end
        end
        H1: begin
          if (ack_s) begin
            if (data_s[6:0] == 7'd0) begin
              done_r  <= 1'b1;
              state_r <= FIN;
            end else if (data_s[4:0] != 5'd0) begin
              pal_r    <= data_s[7:5];
              wfield_r <= data_s[4:0];
              ext_r    <= 1'b0;
              ind_r    <= 1'b0;
              state_r  <= H2;
            end else begin
              wm_r    <= data_s[7];
              ind_r   <= data_s[5];
              ext_r   <= 1'b1;
              state_r <= H2;
            end
          end
        end
        H2: begin
          if (ack_s) begin
            hi_r    <= data_s;
            state_r <= ext_r ? H3 : H4;
          end
        end
        H3: begin
          if (ack_s) begin
            pal_r    <= data_s[7:5];
            wfield_r <= data_s[4:0];
            state_r  <= H4;
          end
        end
        H4: begin
          if (ack_s) begin
            input_addr_r <= data_s;
            input_w_r    <= 1'b1;
            palette_r    <= pal_r;
            palette_w_r  <= 1'b1;
            wm_w_r       <= ext_r;
            if (ext_r) begin
              wm_out_r <= wm_r;
            end
            state_r <= EMIT;
          end
        end
        EMIT: begin
          count_r <= count_inc_s;
          if (ind_r) begin
            if (count_inc_s == MAX_C) begin
              overrun_r <= 1'b1;
              done_r    <= 1'b1;
              state_r   <= FIN;
            end else begin
              state_r <= H0;
            end
          end else begin
            // Width field 0 means a full 32-byte object.
            n_r     <= 6'd32 - {1'b0, wfield_r};
            idx_r   <= 6'd0;
            state_r <= GFX;
          end
        end
        GFX: begin
          if (ack_s) begin
            pixels_r   <= data_s;
            pixels_w_r <= 1'b1;
            if (idx_r == n_r - 6'd1) begin
              if (count_r == MAX_C) begin
                overrun_r <= 1'b1;
                done_r    <= 1'b1;
                state_r   <= FIN;
              end else begin
                state_r <= H0;
              end
            end else begin
              idx_r <= idx_r + 6'd1;
            end
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_REQ    = req_r;
  assign bus.MEM_ADDR   = addr_r;
  assign bus.INPUT_ADDR = input_addr_r;
  assign bus.INPUT_W    = input_w_r;
  assign bus.PALETTE    = palette_r;
  assign bus.PALETTE_W  = palette_w_r;
  assign bus.WM         = wm_out_r;
  assign bus.WM_W       = wm_w_r;
  assign bus.PIXELS     = pixels_r;
  assign bus.PIXELS_W   = pixels_w_r;
  assign bus.BUSY       = busy_r;
  assign bus.DONE       = done_r;
  assign bus.OVERRUN    = overrun_r;
endmodule

// File: tb/tb_dl_fetch.sv
// Bench for dl_fetch: a 64 KiB memory answers the req/ack port with random latency and a
// list-walking reference model predicts the read addresses and the ordered strobe stream.
module tb_dl_fetch;
  logic clk;
  logic rst_n;
  logic sel;
  int   passed;
  int   failed;
  int   total;

  logic [7:0]  mem [0:65535];
  logic [15:0] wp;
  logic [31:0] obs_ev[$];
  logic [31:0] exp_ev[$];
  logic [15:0] obs_rd[$];
  logic [15:0] exp_rd[$];
  int          obs_done;
  logic        exp_ovr;

  dl_fetch_if bus_a ();
  dl_fetch_if bus_b ();

  dl_fetch #(.MAX_ENTRIES(32)) dut_a (.SYSCLK(clk), .RESET_N(rst_n), .bus(bus_a.master));
  dl_fetch #(.MAX_ENTRIES(2))  dut_b (.SYSCLK(clk), .RESET_N(rst_n), .bus(bus_b.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        o_req, o_input_w, o_palette_w, o_wm, o_wm_w, o_pixels_w, o_busy, o_done, o_overrun;
  logic [15:0] o_addr;
  logic [7:0]  o_input_addr, o_pixels;
  logic [2:0]  o_palette;
  assign o_req        = sel ? bus_b.MEM_REQ    : bus_a.MEM_REQ;
  assign o_addr       = sel ? bus_b.MEM_ADDR   : bus_a.MEM_ADDR;
  assign o_input_addr = sel ? bus_b.INPUT_ADDR : bus_a.INPUT_ADDR;
  assign o_input_w    = sel ? bus_b.INPUT_W    : bus_a.INPUT_W;
  assign o_palette    = sel ? bus_b.PALETTE    : bus_a.PALETTE;
  assign o_palette_w  = sel ? bus_b.PALETTE_W  : bus_a.PALETTE_W;
  assign o_wm         = sel ? bus_b.WM         : bus_a.WM;
  assign o_wm_w       = sel ? bus_b.WM_W       : bus_a.WM_W;
  assign o_pixels     = sel ? bus_b.PIXELS     : bus_a.PIXELS;
  assign o_pixels_w   = sel ? bus_b.PIXELS_W   : bus_a.PIXELS_W;
  assign o_busy       = sel ? bus_b.BUSY       : bus_a.BUSY;
  assign o_done       = sel ? bus_b.DONE       : bus_a.DONE;
  assign o_overrun    = sel ? bus_b.OVERRUN    : bus_a.OVERRUN;

  function automatic logic [31:0] obj_ev(input logic [2:0] pal, input logic wmw, input logic wm,
                                         input logic [7:0] hpos);
    return {16'h0100, 1'b0, pal, 2'b00, wmw, wmw & wm, hpos};
  endfunction

  function automatic logic [31:0] pix_ev(input logic [7:0] b);
    return {16'h0200, 8'h00, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 16'd1;
  endtask

  task automatic set_start(input logic v);
    bus_a.DL_START = v & ~sel;
    bus_b.DL_START = v & sel;
  endtask

  task automatic drive_ack(input logic a, input logic [7:0] d);
    bus_a.MEM_ACK  = a;
    bus_b.MEM_ACK  = a;
    bus_a.MEM_DATA = d;
    bus_b.MEM_DATA = d;
  endtask

  task automatic set_ctl(input logic [15:0] dl, input logic [3:0] off, input logic abort);
    bus_a.DL_ADDR  = dl;
    bus_b.DL_ADDR  = dl;
    bus_a.OFFSET   = off;
    bus_b.OFFSET   = off;
    bus_a.DL_ABORT = abort;
    bus_b.DL_ABORT = abort;
  endtask

  // Reference: walk the list in memory the way the display list is defined.
  task automatic model(input logic [15:0] dl, input logic [3:0] off, input int maxe);
    logic [15:0] p, base, a;
    logic [7:0]  lo, b1, hi, b3, hp, hs;
    logic [2:0]  pal;
    logic [4:0]  w;
    logic        ext, ind, wm;
    int          cnt, n;
    bit          fin;
    exp_ev.delete();
    exp_rd.delete();
    exp_ovr = 1'b0;
    p = dl;
    cnt = 0;
    fin = 1'b0;
    while (!fin) begin
      exp_rd.push_back(p); lo = mem[p]; p = p + 16'd1;
      exp_rd.push_back(p); b1 = mem[p]; p = p + 16'd1;
      if (b1[6:0] == 7'd0) begin
        fin = 1'b1;
      end else begin
        ext = (b1[4:0] == 5'd0);
        ind = ext & b1[5];
        wm  = b1[7];
        exp_rd.push_back(p); hi = mem[p]; p = p + 16'd1;
        if (ext) begin
          exp_rd.push_back(p); b3 = mem[p]; p = p + 16'd1;
          pal = b3[7:5];
          w   = b3[4:0];
        end else begin
          pal = b1[7:5];
          w   = b1[4:0];
        end
        exp_rd.push_back(p); hp = mem[p]; p = p + 16'd1;
        exp_ev.push_back(obj_ev(pal, ext, wm, hp));
        cnt++;
        if (!ind) begin
          n = (w == 5'd0) ? 32 : 32 - int'(w);
          hs = hi + {4'd0, off};
          base = {hs, lo};
          for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            exp_rd.push_back(a);
            exp_ev.push_back(pix_ev(mem[a]));
          end
        end
        if (cnt == maxe) begin
          exp_ovr = 1'b1;
          fin = 1'b1;
        end
      end
    end
  endtask

  // Start one list, answer the memory port with random latency, record everything until BUSY falls.
  task automatic run(input logic s, input logic [15:0] dl, input logic [3:0] off, input bit poke);
    int          wait_c, unstable, overlap, pal_mis, cyc;
    bit          pend;
    logic [15:0] paddr;
    sel = s;
    obs_ev.delete();
    obs_rd.delete();
    obs_done = 0;
    unstable = 0; overlap = 0; pal_mis = 0; pend = 1'b0; wait_c = 0; paddr = 16'd0;
    @(posedge clk); #1;
    set_ctl(dl, off, 1'b0);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    cyc = 0;
    while (cyc < 4000) begin
      if (o_input_w) obs_ev.push_back(obj_ev(o_palette, o_wm_w, o_wm, o_input_addr));
      if (o_pixels_w) obs_ev.push_back(pix_ev(o_pixels));
      if (o_input_w && o_pixels_w) overlap++;
      if (o_input_w != o_palette_w) pal_mis++;
      if (o_done) obs_done++;
      if (!o_busy) break;
      if (poke && cyc == 3) begin
        set_ctl(~dl, off, 1'b0);
        set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      if (o_req) begin
        if (!pend) begin
          pend = 1'b1;
          paddr = o_addr;
          wait_c = $urandom_range(0, 2);
        end else if (o_addr != paddr) begin
          unstable++;
        end
        if (wait_c == 0) begin
          drive_ack(1'b1, mem[o_addr]);
          obs_rd.push_back(o_addr);
          pend = 1'b0;
        end else begin
          wait_c--;
          drive_ack(1'b0, 8'h00);
        end
      end else begin
        drive_ack(1'b0, 8'h00);
        pend = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive_ack(1'b0, 8'h00);
    set_start(1'b0);
    chk("run_in_budget", 32'(cyc < 4000), 32'd1);
    chk("addr_stable", 32'(unstable), 32'd0);
    chk("no_strobe_overlap", 32'(overlap), 32'd0);
    chk("pal_input_pair", 32'(pal_mis), 32'd0);
  endtask

  task automatic compare(input string name);
    int n;
    chk({name, " done"}, 32'(obs_done), 32'd1);
    chk({name, " overrun"}, 32'(o_overrun), 32'(exp_ovr));
    chk({name, " n_reads"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
    chk({name, " n_events"}, 32'(obs_ev.size()), 32'(exp_ev.size()));
    n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s rd%0d", name, i), 32'(obs_rd[i]), 32'(exp_rd[i]));
    n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s ev%0d", name, i), obs_ev[i], exp_ev[i]);
  endtask

  task automatic build_random(input logic [15:0] dl);
    int ne;
    logic [4:0] w;
    logic [1:0] b65;
    wp = dl;
    ne = $urandom_range(1, 4);
    for (int e = 0; e < ne; e++) begin
      wr(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        w = 5'($urandom_range(1, 31));
        wr({3'($urandom), w});
        wr(8'($urandom));
        wr(8'($urandom));
      end else begin
        b65 = 2'($urandom_range(1, 3));
        wr({1'($urandom), b65, 5'd0});
        wr(8'($urandom));
        wr(8'($urandom));
        wr(8'($urandom));
      end
    end
    wr(8'($urandom));
    wr(8'h00);
  endtask

  initial begin
    logic [15:0] dl;
    logic [3:0]  off;
    bit          found, saw_obj;
    int          late;
    passed = 0; failed = 0; total = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    set_ctl(16'h0000, 4'd0, 1'b0);
    set_start(1'b0);
    bus_a.DL_START = 1'b0;
    bus_b.DL_START = 1'b0;
    drive_ack(1'b0, 8'h00);
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_outputs", {bus_a.MEM_REQ, bus_a.MEM_ADDR, bus_a.INPUT_ADDR, bus_a.INPUT_W,
        bus_a.PALETTE_W, bus_a.WM_W, bus_a.PIXELS_W, bus_a.BUSY, bus_a.DONE, bus_a.OVERRUN}, 32'd0);
    chk("reset_b_outputs", {bus_b.MEM_REQ, bus_b.BUSY, bus_b.DONE, bus_b.OVERRUN, bus_b.PIXELS}, 32'd0);
    rst_n = 1'b1;

    // 4-byte header, width 29, OFFSET 2.
    wp = 16'h1000;
    wr(8'h00); wr(8'hE3); wr(8'h80); wr(8'h10); wr(8'h55); wr(8'h00);
    model(16'h1000, 4'd2, 32);
    run(1'b0, 16'h1000, 4'd2, 1'b0);
    compare("t1");
    chk("t1_obj", obs_ev[0], obj_ev(3'd7, 1'b0, 1'b0, 8'h10));
    chk("t1_nrd", 32'(obs_rd.size()), 32'd35);
    chk("t1_first_gfx", 32'(obs_rd[4]), 32'h8200);
    chk("t1_last_gfx", 32'(obs_rd[32]), 32'h821C);

    // 5-byte header with write mode, single byte.
    wp = 16'h3000;
    wr(8'h40); wr(8'hC0); wr(8'h90); wr(8'h5F); wr(8'h20); wr(8'h00); wr(8'h00);
    model(16'h3000, 4'd2, 32);
    run(1'b0, 16'h3000, 4'd2, 1'b1);
    compare("t2");
    chk("t2_obj", obs_ev[0], obj_ev(3'd2, 1'b1, 1'b1, 8'h20));
    chk("t2_gfx", 32'(obs_rd[5]), 32'h9240);

    // High-byte and 16-bit address wrap.
    wp = 16'h4000;
    wr(8'hFE); wr(8'h40); wr(8'hFF); wr(8'h3C); wr(8'h33); wr(8'h00); wr(8'h00);
    model(16'h4000, 4'd3, 32);
    run(1'b0, 16'h4000, 4'd3, 1'b0);
    compare("t3");
    chk("t3_a0", 32'(obs_rd[5]), 32'h02FE);
    chk("t3_a1", 32'(obs_rd[6]), 32'h02FF);
    chk("t3_a2", 32'(obs_rd[7]), 32'h0300);
    chk("t3_a3", 32'(obs_rd[8]), 32'h0301);

    // Indirect object: strobes only, no graphics reads.
    wp = 16'h5000;
    wr(8'h10); wr(8'h60); wr(8'h20); wr(8'h01); wr(8'h44); wr(8'h00); wr(8'h00);
    model(16'h5000, 4'd1, 32);
    run(1'b0, 16'h5000, 4'd1, 1'b0);
    compare("t4");
    chk("t4_nrd", 32'(obs_rd.size()), 32'd7);
    chk("t4_obj", obs_ev[0], obj_ev(3'd0, 1'b1, 1'b0, 8'h44));

    // Entry limit of 2 on a 3-entry list, then sticky OVERRUN until next start.
    wp = 16'h6000;
    for (int e = 0; e < 3; e++) begin
      wr(8'(8'h20 + e)); wr(8'h3E); wr(8'h70); wr(8'(8'h08 * e));
    end
    wr(8'h00); wr(8'h00);
    model(16'h6000, 4'd0, 2);
    run(1'b1, 16'h6000, 4'd0, 1'b0);
    compare("t5");
    chk("t5_overrun", 32'(o_overrun), 32'd1);
    chk("t5_objs", 32'(obs_ev.size()), 32'd6);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_overrun_sticky", 32'(o_overrun), 32'd1);
    wp = 16'h6100;
    wr(8'h00); wr(8'h80);
    model(16'h6100, 4'd0, 2);
    run(1'b1, 16'h6100, 4'd0, 1'b0);
    compare("t5b");
    chk("t5b_overrun_clear", 32'(o_overrun), 32'd0);

    // Abort on the same cycle as the first graphics ACK.
    sel = 1'b0;
    wp = 16'h2000;
    wr(8'h00); wr(8'hE3); wr(8'h80); wr(8'h10); wr(8'h00); wr(8'h00);
    @(posedge clk); #1;
    set_ctl(16'h2000, 4'd2, 1'b0);
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    found = 1'b0;
    saw_obj = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (o_input_w) saw_obj = 1'b1;
      if (o_req && o_addr == 16'h8200) begin
        drive_ack(1'b1, mem[16'h8200]);
        set_ctl(16'h2000, 4'd2, 1'b1);
        found = 1'b1;
      end else if (o_req) begin
        drive_ack(1'b1, mem[o_addr]);
      end else begin
        drive_ack(1'b0, 8'h00);
      end
      @(posedge clk); #1;
    end
    drive_ack(1'b0, 8'h00);
    set_ctl(16'h2000, 4'd2, 1'b0);
    chk("abort_reached_gfx", 32'(found), 32'd1);
    chk("abort_obj_before", 32'(saw_obj), 32'd1);
    chk("abort_pixels_w", 32'(o_pixels_w), 32'd0);
    chk("abort_req", 32'(o_req), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    late = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      late += int'(o_done) + int'(o_pixels_w) + int'(o_req);
    end
    chk("abort_quiet_after", 32'(late), 32'd0);

    // Randomised lists on the full-size instance.
    for (int t = 0; t < 8; t++) begin
      dl  = 16'($urandom);
      off = 4'($urandom);
      build_random(dl);
      model(dl, off, 32);
      run(1'b0, dl, off, t[0]);
      compare($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
